i2c_byte_shifter: RTL and testbench
===================================

# i2c_byte_shifter

Bit-level I2C byte engine directly downstream of the I2C control FSM. It consumes the FSM's load/shift/read-write commands and serialises one byte plus its ACK bit on SDA, timed by the SCL edges it observes. It returns the `done`/ACK status the FSM branches on, along with the received byte. SCL generation and stretching live elsewhere; this block only follows SCL.

## Interface
- SYNC_STAGES, 2, synchroniser depth for i_scl_in/i_sda_in (min 2)
- i_sys_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  block enable; low = synchronous abort to IDLE
- i_load  in  1  start byte; level-tolerant, sampled only in IDLE
- i_rw_mode  in  1  0 = transmit byte / receive ACK; 1 = receive byte / send ACK
- i_tx_data  in  8  byte to transmit, MSB first
- i_ack_en  in  1  in receive mode: 1 = drive ACK (low), 0 = NACK (release)
- i_scl_in  in  1  SCL from pad buffer (async)
- i_sda_in  in  1  SDA from pad buffer (async)
- o_sda_out  out  1  constant 0 (open-drain data)
- o_sda_oe  out  1  1 = pull SDA low
- o_rx_data  out  8  last received byte
- o_shift_done  out  1  one-cycle pulse, byte + ACK bit complete
- o_ack_received  out  1  transmit mode: 1 = slave ACKed (SDA low at ACK rise)
- o_arb_lost  out  1  one-cycle pulse, arbitration lost during transmit
- o_busy  out  1  high in every state except IDLE
- o_bit_cnt  out  4  current bit index: 0-7 data, 8 ACK

## Operation
- Synchronisation:
  - i_scl_in and i_sda_in each pass through a SYNC_STAGES flop chain.
  - scl_rise = sync & ~prev; scl_fall = ~sync & prev.
- States: IDLE, DATA, ACK, DONE.
- IDLE:
  - On i_load && i_enable: capture i_tx_data into shreg, i_rw_mode into rw_q, i_ack_en into ack_q.
  - Set bit_cnt=0 and go to DATA.
  - In transmit, drive shreg[7] in the same transition: oe = ~shreg[7]. SCL is low after START by contract.
- DATA, transmit:
  - On scl_rise: if oe==0 and synced SDA==0, pulse o_arb_lost, release SDA, go to IDLE. No done pulse.
  - On scl_fall: shift shreg left and increment bit_cnt.
    - bit_cnt 7→8: go to ACK with oe=0.
    - Otherwise: oe = ~next MSB.
- DATA, receive:
  - oe=0 throughout.
  - On scl_rise: shreg = {shreg[6:0], sda_sync}.
  - On scl_fall: increment bit_cnt. At 7→8, go to ACK with oe = ack_q.
- ACK:
  - Transmit: on scl_rise, latch ack_rx = ~sda_sync.
  - Both modes: on scl_fall, release SDA and go to DONE.
- DONE (one cycle):
  - Pulse o_shift_done.
  - Update o_ack_received (transmit only; receive leaves it unchanged).
  - Update o_rx_data (receive only).
  - Go to IDLE.
- Loads:
  - i_load is ignored outside IDLE.
  - A load still asserted in the cycle after DONE starts a new byte. This is intentional for back-to-back bytes.
- Abort: i_enable low in any state gives next cycle IDLE, oe=0, bit_cnt=0, and no done pulse. o_rx_data and o_ack_received hold.
- Simultaneous scl_rise and scl_fall cannot occur. A glitch shorter than SYNC_STAGES cycles may be missed; this is accepted.

## Timing
- Reset values: o_sda_out=0, o_sda_oe=0, o_rx_data=8'h00, o_shift_done=0, o_ack_received=0, o_arb_lost=0, o_busy=0, o_bit_cnt=0. State = IDLE; synchroniser flops reset to 1.
- Reset mid-byte releases SDA asynchronously.
- Pad SCL edge to reaction: SYNC_STAGES+1 cycles. SDA change to oe update after scl_fall: SYNC_STAGES+2 cycles. SCL low time must exceed this.
- Load to first oe: 1 cycle.
- Byte latency: 9 SCL falls after load, then +1 cycle to o_shift_done.
- o_shift_done and o_arb_lost are exactly 1 cycle wide and mutually exclusive.

## Structure
- i2c_pkg holds:
  - state enum (IDLE/DATA/ACK/DONE)
  - I2C_ACK=1'b0 and I2C_NACK=1'b1
  - BIT_ACK=4'd8
  - RW_TX/RW_RX constants
- Sub-module i2c_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detector, instantiated for SCL and SDA. Its sync output resets to 1.

## Test plan
- Transmit 8'hA5, slave ACKs → oe pattern per bit = ~{1,0,1,0,0,1,0,1}; SDA released in ACK; o_shift_done pulses once; o_ack_received=1.
- Transmit 8'h3C, SDA high at ACK rise → o_ack_received=0; done pulse.
- Receive with SDA bits 8'h96, i_ack_en=1 → oe=1 only in ACK bit; o_rx_data=8'h96 with done pulse.
- Receive with i_ack_en=0 → oe stays 0 for all 9 bits; o_rx_data updated.
- Transmit 8'hFF, external SDA pulled low at bit 3 rise → o_arb_lost pulses; oe=0; IDLE; no o_shift_done.
- i_enable low after bit 4, and separately reset asserted mid-byte → oe=0, o_busy=0, bit_cnt=0; i_load while busy is ignored; held i_load restarts after DONE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte shifter and its helpers.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [3:0] BIT_ACK  = 4'd8;
  localparam logic       RW_TX    = 1'b0;
  localparam logic       RW_RX    = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad input plus rise/fall detect.
// All flops reset high so an idle (pulled-up) bus produces no edge at reset.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/i2c_byte_shifter.sv
// Bit-level I2C byte engine: shifts one byte plus ACK on SDA, paced by the
// SCL edges it observes, and reports done/ACK/arbitration status.
module i2c_byte_shifter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_load,
  input  logic       i_rw_mode,
  input  logic [7:0] i_tx_data,
  input  logic       i_ack_en,
  input  logic       i_scl_in,
  input  logic       i_sda_in,
  output logic       o_sda_out,
  output logic       o_sda_oe,
  output logic [7:0] o_rx_data,
  output logic       o_shift_done,
  output logic       o_ack_received,
  output logic       o_arb_lost,
  output logic       o_busy,
  output logic [3:0] o_bit_cnt
);

  localparam logic [3:0] LAST_DATA = BIT_ACK - 4'd1;

  logic scl_rise, scl_fall, unused_scl_sync;
  logic sda_sync, unused_sda_rise, unused_sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (i_sys_clk),
    .rst_n (i_rst_n),
    .din   (i_scl_in),
    .sync  (unused_scl_sync),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (i_sys_clk),
    .rst_n (i_rst_n),
    .din   (i_sda_in),
    .sync  (sda_sync),
    .rise  (unused_sda_rise),
    .fall  (unused_sda_fall)
  );

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic       oe, oe_nxt;
  logic       rw_q, rw_nxt;
  logic       ack_q, ack_q_nxt;
  logic       ack_rx, ack_rx_nxt;
  logic [7:0] rx_data, rx_data_nxt;
  logic       ack_received, ack_received_nxt;
  logic       arb_lost, arb_lost_nxt;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      oe           <= 1'b0;
      rw_q         <= RW_TX;
      ack_q        <= 1'b0;
      ack_rx       <= 1'b0;
      rx_data      <= 8'h00;
      ack_received <= 1'b0;
      arb_lost     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      oe           <= oe_nxt;
      rw_q         <= rw_nxt;
      ack_q        <= ack_q_nxt;
      ack_rx       <= ack_rx_nxt;
      rx_data      <= rx_data_nxt;
      ack_received <= ack_received_nxt;
      arb_lost     <= arb_lost_nxt;
    end
  end

  // Shift register carries payload only; its contents are don't-care in IDLE.
  always_ff @(posedge i_sys_clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt        = state;
    shreg_nxt        = shreg;
    bit_cnt_nxt      = bit_cnt;
    oe_nxt           = oe;
    rw_nxt           = rw_q;
    ack_q_nxt        = ack_q;
    ack_rx_nxt       = ack_rx;
    rx_data_nxt      = rx_data;
    ack_received_nxt = ack_received;
    arb_lost_nxt     = 1'b0;

    if (!i_enable) begin
      state_nxt   = ST_IDLE;
      oe_nxt      = 1'b0;
      bit_cnt_nxt = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          oe_nxt      = 1'b0;
          bit_cnt_nxt = 4'd0;
          if (i_load) begin
            shreg_nxt = i_tx_data;
            rw_nxt    = i_rw_mode;
            ack_q_nxt = i_ack_en;
            state_nxt = ST_DATA;
            // SCL is already low after START, so the MSB goes out immediately.
            oe_nxt    = (i_rw_mode == RW_TX) ? ~i_tx_data[7] : 1'b0;
          end
        end
        ST_DATA: begin
          if (rw_q == RW_TX) begin
            // We released SDA to send a 1 but someone else holds it low.
            if (scl_rise && !oe && !sda_sync) begin
              arb_lost_nxt = 1'b1;
              oe_nxt       = 1'b0;
              bit_cnt_nxt  = 4'd0;
              state_nxt    = ST_IDLE;
            end else if (scl_fall) begin
              shreg_nxt   = {shreg[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 4'd1;
              if (bit_cnt == LAST_DATA) begin
                oe_nxt    = 1'b0;
                state_nxt = ST_ACK;
              end else begin
                oe_nxt = ~shreg[6];
              end
            end
          end else begin
            oe_nxt = 1'b0;
            if (scl_rise) begin
              shreg_nxt = {shreg[6:0], sda_sync};
            end else if (scl_fall) begin
              bit_cnt_nxt = bit_cnt + 4'd1;
              if (bit_cnt == LAST_DATA) begin
                oe_nxt    = ack_q;
                state_nxt = ST_ACK;
              end
            end
          end
        end
        ST_ACK: begin
          if (scl_rise && rw_q == RW_TX) begin
            ack_rx_nxt = (sda_sync != I2C_NACK);
          end
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rw_q == RW_TX) ack_received_nxt = ack_rx;
          else               rx_data_nxt      = shreg;
          bit_cnt_nxt = 4'd0;
          state_nxt   = ST_IDLE;
        end
        default: begin
          state_nxt   = ST_IDLE;
          oe_nxt      = 1'b0;
          bit_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  assign o_sda_out      = I2C_ACK;
  assign o_sda_oe       = oe;
  assign o_rx_data      = rx_data;
  assign o_shift_done   = (state == ST_DONE);
  assign o_ack_received = ack_received;
  assign o_arb_lost     = arb_lost;
  assign o_busy         = (state != ST_IDLE);
  assign o_bit_cnt      = bit_cnt;

endmodule

// File: tb/tb_i2c_byte_shifter.sv
// Directed bench for i2c_byte_shifter: a bench-side SCL master and open-drain
// slave drive bytes through the shifter and compare against hand-made vectors.
module tb_i2c_byte_shifter;

  localparam int LOW  = 8;
  localparam int HIGH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic       rw_mode = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ack_en = 1'b0;
  logic       scl = 1'b1;
  logic       slave_low = 1'b0;
  logic       sda_pad;

  logic       sda_out, sda_oe, shift_done, ack_received, arb_lost, busy;
  logic [7:0] rx_data;
  logic [3:0] bit_cnt;

  assign sda_pad = ~(sda_oe | slave_low);

  i2c_byte_shifter #(.SYNC_STAGES(2)) dut (
    .i_sys_clk      (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_load         (load),
    .i_rw_mode      (rw_mode),
    .i_tx_data      (tx_data),
    .i_ack_en       (ack_en),
    .i_scl_in       (scl),
    .i_sda_in       (sda_pad),
    .o_sda_out      (sda_out),
    .o_sda_oe       (sda_oe),
    .o_rx_data      (rx_data),
    .o_shift_done   (shift_done),
    .o_ack_received (ack_received),
    .o_arb_lost     (arb_lost),
    .o_busy         (busy),
    .o_bit_cnt      (bit_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int arb_cnt = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (shift_done) done_cnt++;
    if (arb_lost) arb_cnt++;
    if (shift_done && arb_lost) overlap_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One SCL period per bit; mask[i] makes the slave pull SDA low for bit i.
  task automatic run_bits(input logic [8:0] mask, input int nbits, output logic [8:0] oe_seen);
    oe_seen = '0;
    for (int i = 0; i < nbits; i++) begin
      slave_low = mask[i];
      repeat (LOW) @(posedge clk);
      #1 scl = 1'b1;
      repeat (HIGH / 2) @(posedge clk);
      @(negedge clk);
      oe_seen[i] = sda_oe;
      repeat (HIGH / 2) @(posedge clk);
      #1 scl = 1'b0;
    end
    slave_low = 1'b0;
  endtask

  task automatic start_byte(input logic rw, input logic [7:0] d, input logic ae);
    scl = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rw_mode = rw;
    tx_data = d;
    ack_en  = ae;
    load    = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({sda_out, sda_oe, rx_data, shift_done, ack_received, arb_lost, busy, bit_cnt} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got oe=%b rx=%h done=%b ack=%b arb=%b busy=%b cnt=%0d required all zero",
               sda_oe, rx_data, shift_done, ack_received, arb_lost, busy, bit_cnt);
    end
  endtask

  task automatic test_rx_ack;
    logic [8:0] seen;
    int d0;
    d0 = done_cnt;
    start_byte(1'b1, 8'h00, 1'b1);
    run_bits(9'h096, 9, seen);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen !== 9'h100) begin miscompares++; $display("FAIL rx_ack_oe got %h required %h", seen, 9'h100); end
    vectors++;
    if (rx_data !== 8'h96) begin miscompares++; $display("FAIL rx_ack_data got %h required %h", rx_data, 8'h96); end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rx_ack_done got %0d required 1", done_cnt - d0); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rx_ack_busy got %b required 0", busy); end
  endtask

  task automatic test_rx_nack;
    logic [8:0] seen;
    int d0;
    d0 = done_cnt;
    start_byte(1'b1, 8'h00, 1'b0);
    run_bits(9'h0A5, 9, seen);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen !== 9'h000) begin miscompares++; $display("FAIL rx_nack_oe got %h required %h", seen, 9'h000); end
    vectors++;
    if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL rx_nack_data got %h required %h", rx_data, 8'h5A); end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rx_nack_done got %0d required 1", done_cnt - d0); end
    vectors++;
    if (ack_received !== 1'b0) begin miscompares++; $display("FAIL rx_nack_ackrx got %b required 0", ack_received); end
  endtask

  task automatic test_tx_nack;
    logic [8:0] seen;
    int d0;
    d0 = done_cnt;
    start_byte(1'b0, 8'h3C, 1'b0);
    vectors++;
    if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL tx_first_oe got %b required 1", sda_oe); end
    run_bits(9'h000, 9, seen);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen !== 9'h0C3) begin miscompares++; $display("FAIL tx_nack_oe got %h required %h", seen, 9'h0C3); end
    vectors++;
    if (ack_received !== 1'b0) begin miscompares++; $display("FAIL tx_nack_ackrx got %b required 0", ack_received); end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL tx_nack_done got %0d required 1", done_cnt - d0); end
    vectors++;
    if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL tx_nack_rxhold got %h required %h", rx_data, 8'h5A); end
  endtask

  task automatic test_tx_ack;
    logic [8:0] seen;
    int d0;
    d0 = done_cnt;
    start_byte(1'b0, 8'hA5, 1'b0);
    run_bits(9'h100, 9, seen);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen !== 9'h05A) begin miscompares++; $display("FAIL tx_ack_oe got %h required %h", seen, 9'h05A); end
    vectors++;
    if (ack_received !== 1'b1) begin miscompares++; $display("FAIL tx_ack_ackrx got %b required 1", ack_received); end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL tx_ack_done got %0d required 1", done_cnt - d0); end
    vectors++;
    if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL tx_ack_release got %b required 0", sda_oe); end
  endtask

  task automatic test_arbitration;
    logic [8:0] seen;
    int d0, a0;
    d0 = done_cnt;
    a0 = arb_cnt;
    start_byte(1'b0, 8'hFF, 1'b0);
    run_bits(9'h008, 4, seen);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen !== 9'h000) begin miscompares++; $display("FAIL arb_oe got %h required %h", seen, 9'h000); end
    vectors++;
    if (arb_cnt - a0 !== 1) begin miscompares++; $display("FAIL arb_pulse got %0d required 1", arb_cnt - a0); end
    vectors++;
    if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL arb_no_done got %0d required 0", done_cnt - d0); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arb_busy got %b required 0", busy); end
    vectors++;
    if (bit_cnt !== 4'd0) begin miscompares++; $display("FAIL arb_bitcnt got %0d required 0", bit_cnt); end
    vectors++;
    if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL arb_release got %b required 0", sda_oe); end
  endtask

  task automatic test_abort;
    logic [8:0] seen;
    int d0;
    d0 = done_cnt;
    start_byte(1'b0, 8'h00, 1'b0);
    run_bits(9'h000, 5, seen);
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bit_cnt !== 4'd5) begin miscompares++; $display("FAIL abort_pre_bitcnt got %0d required 5", bit_cnt); end
    vectors++;
    if ({busy, sda_oe} !== 2'b11) begin miscompares++; $display("FAIL abort_pre_state got busy=%b oe=%b required busy=1 oe=1", busy, sda_oe); end
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, sda_oe, bit_cnt} !== 6'h00) begin miscompares++; $display("FAIL abort_idle got busy=%b oe=%b cnt=%0d required 0 0 0", busy, sda_oe, bit_cnt); end
    vectors++;
    if (ack_received !== 1'b1) begin miscompares++; $display("FAIL abort_ackhold got %b required 1", ack_received); end
    vectors++;
    if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL abort_rxhold got %h required %h", rx_data, 8'h5A); end
    #1 enable = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d required 0", done_cnt - d0); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle got %b required 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] seen1, seen2;
    int d0;
    d0 = done_cnt;
    scl = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rw_mode = 1'b0;
    tx_data = 8'hA5;
    ack_en  = 1'b0;
    load    = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h0F;
    run_bits(9'h100, 9, seen1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, bit_cnt} !== 5'h10) begin miscompares++; $display("FAIL b2b_restart got busy=%b cnt=%0d required busy=1 cnt=0", busy, bit_cnt); end
    #1 load = 1'b0;
    run_bits(9'h000, 9, seen2);
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (seen1 !== 9'h05A) begin miscompares++; $display("FAIL b2b_first_oe got %h required %h", seen1, 9'h05A); end
    vectors++;
    if (seen2 !== 9'h00F) begin miscompares++; $display("FAIL b2b_second_oe got %h required %h", seen2, 9'h00F); end
    vectors++;
    if (done_cnt - d0 !== 2) begin miscompares++; $display("FAIL b2b_done got %0d required 2", done_cnt - d0); end
    vectors++;
    if ({busy, ack_received} !== 2'b00) begin miscompares++; $display("FAIL b2b_end got busy=%b ack=%b required 0 0", busy, ack_received); end
  endtask

  task automatic test_reset_mid;
    logic [8:0] seen;
    start_byte(1'b0, 8'h00, 1'b0);
    run_bits(9'h000, 3, seen);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_oe got %b required 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_oe got %b required 0", sda_oe); end
    @(negedge clk);
    vectors++;
    if ({busy, bit_cnt} !== 5'h00) begin miscompares++; $display("FAIL rstmid_idle got busy=%b cnt=%0d required 0 0", busy, bit_cnt); end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_rx got %h required 00", rx_data); end
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    #2 rst_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    test_rx_ack();
    test_rx_nack();
    test_tx_nack();
    test_tx_ack();
    test_arbitration();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (overlap_cnt !== 0) begin miscompares++; $display("FAIL done_arb_overlap got %0d required 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
